// File: rtl/v810_icache_pkg.sv
// Shared types and constants for the V810 instruction-cache fill path.
// Word addresses split as {tag[21:0], index[6:0], sub}.
package v810_icache_pkg;

  localparam int unsigned LINES   = 128;
  localparam int unsigned INDEX_W = 7;
  localparam int unsigned TAG_W   = 22;
  localparam int unsigned SUBS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRIT,
    ST_OTHER,
    ST_TAGWR,
    ST_CLEAR
  } fill_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               sub;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [29:0] waddr);
    addr_split_t s;
    s.tag   = waddr[29:8];
    s.index = waddr[7:1];
    s.sub   = waddr[0];
    return s;
  endfunction

endpackage

// File: rtl/v810_icache_fill.sv
// Line-fill / invalidate engine: critical-word-first refill of a 2-subblock
// line into the data RAM, followed by a tag write; also sweeps all tags invalid.
module v810_icache_fill
  import v810_icache_pkg::*;
#(
  parameter int unsigned index_width = INDEX_W,
  parameter int unsigned tag_width   = TAG_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   miss_req,
  input  logic [29:0]            miss_addr,
  output logic                   fill_done,
  output logic [31:0]            fill_data,
  output logic                   fill_err,
  output logic                   busy,
  input  logic                   clr_req,
  output logic                   clr_done,
  output logic                   bus_req,
  output logic [29:0]            bus_addr,
  input  logic                   bus_ack,
  input  logic                   bus_err,
  input  logic [31:0]            bus_rdata,
  output logic                   dr_wr_en,
  output logic [index_width:0]   dr_wr_address,
  output logic [31:0]            dr_wr_data,
  output logic                   tag_wr_en,
  output logic [index_width-1:0] tag_wr_index,
  output logic [tag_width-1:0]   tag_wr_tag,
  output logic [SUBS-1:0]        tag_wr_valid
);

  fill_state_e            state_q, state_d;
  logic [29:0]            addr_q, addr_d;
  logic [SUBS-1:0]        valid_q, valid_d;
  logic [index_width-1:0] cnt_q, cnt_d;

  logic                   fill_done_q, fill_done_d;
  logic [31:0]            fill_data_q, fill_data_d;
  logic                   fill_err_q, fill_err_d;
  logic                   busy_q, busy_d;
  logic                   clr_done_q, clr_done_d;
  logic                   bus_req_q, bus_req_d;
  logic [29:0]            bus_addr_q, bus_addr_d;
  logic                   dr_wr_en_q, dr_wr_en_d;
  logic [index_width:0]   dr_wr_address_q, dr_wr_address_d;
  logic [31:0]            dr_wr_data_q, dr_wr_data_d;
  logic                   tag_wr_en_q, tag_wr_en_d;
  logic [index_width-1:0] tag_wr_index_q, tag_wr_index_d;
  logic [tag_width-1:0]   tag_wr_tag_q, tag_wr_tag_d;
  logic [SUBS-1:0]        tag_wr_valid_q, tag_wr_valid_d;

  addr_split_t cur;
  logic        bus_done;

  assign cur      = split_addr(addr_q);
  assign bus_done = bus_req_q & (bus_ack | bus_err);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    valid_d         = valid_q;
    cnt_d           = cnt_q;
    bus_req_d       = bus_req_q;
    bus_addr_d      = bus_addr_q;
    fill_done_d     = 1'b0;
    fill_data_d     = '0;
    fill_err_d      = 1'b0;
    clr_done_d      = 1'b0;
    dr_wr_en_d      = 1'b0;
    dr_wr_address_d = '0;
    dr_wr_data_d    = '0;
    tag_wr_en_d     = 1'b0;
    tag_wr_index_d  = '0;
    tag_wr_tag_d    = '0;
    tag_wr_valid_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = '0;
        if (clr_req) begin
          // Index 0 is issued on entry so the sweep's writes line up with CLEAR.
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          tag_wr_en_d = 1'b1;
        end else if (miss_req) begin
          state_d    = ST_CRIT;
          addr_d     = miss_addr;
          bus_req_d  = 1'b1;
          bus_addr_d = miss_addr;
        end
      end
      ST_CRIT: begin
        if (bus_done) begin
          bus_req_d = 1'b0;
          if (bus_err) begin
            fill_err_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            fill_done_d      = 1'b1;
            fill_data_d      = bus_rdata;
            dr_wr_en_d       = 1'b1;
            dr_wr_address_d  = {cur.index, cur.sub};
            dr_wr_data_d     = bus_rdata;
            valid_d[cur.sub] = 1'b1;
            bus_addr_d       = {cur.tag, cur.index, ~cur.sub};
            state_d          = ST_OTHER;
          end
        end
      end
      ST_OTHER: begin
        // First OTHER cycle is the mandatory idle gap before re-requesting.
        if (!bus_req_q) begin
          bus_req_d = 1'b1;
        end else if (bus_done) begin
          bus_req_d = 1'b0;
          state_d   = ST_TAGWR;
          if (!bus_err) begin
            dr_wr_en_d        = 1'b1;
            dr_wr_address_d   = {cur.index, ~cur.sub};
            dr_wr_data_d      = bus_rdata;
            valid_d[~cur.sub] = 1'b1;
          end
        end
      end
      ST_TAGWR: begin
        tag_wr_en_d    = 1'b1;
        tag_wr_index_d = cur.index;
        tag_wr_tag_d   = cur.tag;
        tag_wr_valid_d = valid_q;
        state_d        = ST_IDLE;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == index_width'(LINES - 1)) begin
          clr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tag_wr_en_d    = 1'b1;
          tag_wr_index_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      cnt_q           <= '0;
      fill_done_q     <= 1'b0;
      fill_data_q     <= '0;
      fill_err_q      <= 1'b0;
      busy_q          <= 1'b0;
      clr_done_q      <= 1'b0;
      bus_req_q       <= 1'b0;
      bus_addr_q      <= '0;
      dr_wr_en_q      <= 1'b0;
      dr_wr_address_q <= '0;
      dr_wr_data_q    <= '0;
      tag_wr_en_q     <= 1'b0;
      tag_wr_index_q  <= '0;
      tag_wr_tag_q    <= '0;
      tag_wr_valid_q  <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      fill_done_q     <= fill_done_d;
      fill_data_q     <= fill_data_d;
      fill_err_q      <= fill_err_d;
      busy_q          <= busy_d;
      clr_done_q      <= clr_done_d;
      bus_req_q       <= bus_req_d;
      bus_addr_q      <= bus_addr_d;
      dr_wr_en_q      <= dr_wr_en_d;
      dr_wr_address_q <= dr_wr_address_d;
      dr_wr_data_q    <= dr_wr_data_d;
      tag_wr_en_q     <= tag_wr_en_d;
      tag_wr_index_q  <= tag_wr_index_d;
      tag_wr_tag_q    <= tag_wr_tag_d;
      tag_wr_valid_q  <= tag_wr_valid_d;
    end
  end

  assign fill_done     = fill_done_q;
  assign fill_data     = fill_data_q;
  assign fill_err      = fill_err_q;
  assign busy          = busy_q;
  assign clr_done      = clr_done_q;
  assign bus_req       = bus_req_q;
  assign bus_addr      = bus_addr_q;
  assign dr_wr_en      = dr_wr_en_q;
  assign dr_wr_address = dr_wr_address_q;
  assign dr_wr_data    = dr_wr_data_q;
  assign tag_wr_en     = tag_wr_en_q;
  assign tag_wr_index  = tag_wr_index_q;
  assign tag_wr_tag    = tag_wr_tag_q;
  assign tag_wr_valid  = tag_wr_valid_q;

endmodule

// File: tb/tb_v810_icache_fill.sv
// Scoreboard bench for v810_icache_fill: a driver queues expected bus, RAM-write
// and fill events; a bus responder and an output monitor consume them.
module tb_v810_icache_fill;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        miss_req, clr_req, bus_ack, bus_err;
  logic [29:0] miss_addr, bus_addr;
  logic [31:0] bus_rdata, fill_data, dr_wr_data;
  logic        fill_done, fill_err, busy, clr_done, bus_req, dr_wr_en, tag_wr_en;
  logic [7:0]  dr_wr_address;
  logic [6:0]  tag_wr_index;
  logic [21:0] tag_wr_tag;
  logic [1:0]  tag_wr_valid;

  always #5 clock = ~clock;

  v810_icache_fill #(.index_width(7), .tag_width(22)) dut (
    .clock(clock), .reset_n(reset_n),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .fill_done(fill_done), .fill_data(fill_data), .fill_err(fill_err), .busy(busy),
    .clr_req(clr_req), .clr_done(clr_done),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata),
    .dr_wr_en(dr_wr_en), .dr_wr_address(dr_wr_address), .dr_wr_data(dr_wr_data),
    .tag_wr_en(tag_wr_en), .tag_wr_index(tag_wr_index), .tag_wr_tag(tag_wr_tag),
    .tag_wr_valid(tag_wr_valid)
  );

  typedef struct {
    logic [29:0] addr;
    logic        err;
    logic        both;
    int unsigned lat;
    logic [31:0] data;
  } plan_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } fill_t;

  plan_t       plan_q[$];
  fill_t       fill_q[$];
  logic [39:0] dr_q[$];
  logic [30:0] tag_q[$];
  int          exp_clr = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: expected events for one miss, from the address arithmetic.
  task automatic push_miss(input logic [29:0] addr, input logic ce, input logic oe,
                           input logic both, input int unsigned lat0,
                           input int unsigned lat1, input logic [31:0] d0,
                           input logic [31:0] d1);
    int unsigned a, sub, idx, tg;
    plan_t p;
    fill_t f;
    a   = addr;
    sub = a % 2;
    idx = (a / 2) % 128;
    tg  = a / 256;
    p.addr = addr; p.err = ce; p.both = both; p.lat = lat0; p.data = d0;
    plan_q.push_back(p);
    f.err = ce; f.data = d0;
    fill_q.push_back(f);
    if (!ce) begin
      dr_q.push_back({8'(idx * 2 + sub), d0});
      p.addr = 30'(a - sub + (1 - sub)); p.err = oe; p.lat = lat1; p.data = d1;
      plan_q.push_back(p);
      if (!oe) dr_q.push_back({8'(idx * 2 + (1 - sub)), d1});
      tag_q.push_back({7'(idx), 22'(tg), oe ? 2'(1 << sub) : 2'b11});
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_fill();
    int unsigned n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(fill_done || fill_err) && n < 500);
    chk("fill_timeout", 64'(fill_done || fill_err), 64'(1));
    if (fill_err) chk("busy_after_err", 64'(busy), 64'(0));
    miss_req = 1'b0;
  endtask

  task automatic wait_dr();
    int unsigned n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dr_wr_en && n < 50);
    chk("dr_wait_timeout", 64'(dr_wr_en), 64'(1));
  endtask

  task automatic do_miss(input logic [29:0] addr, input logic ce, input logic oe,
                         input logic both, input int unsigned lat0,
                         input int unsigned lat1, input logic [31:0] d0);
    wait_idle();
    push_miss(addr, ce, oe, both, lat0, lat1, d0, $urandom);
    miss_addr = addr;
    miss_req  = 1'b1;
    wait_fill();
    if (ce) begin
      @(negedge clock);
      chk("fill_err_single", 64'({fill_err, busy}), 64'(0));
    end
    wait_idle();
  endtask

  // Bus slave: checks request address against the plan, answers after plan.lat.
  plan_t rp;
  initial begin
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus_req && reset_n) begin
        chk("bus_plan_pending", 64'(plan_q.size() > 0), 64'(1));
        if (plan_q.size() > 0) rp = plan_q.pop_front();
        else begin
          rp.addr = '1; rp.err = 1'b0; rp.both = 1'b0; rp.lat = 0; rp.data = '0;
        end
        chk("bus_addr", 64'(bus_addr), 64'(rp.addr));
        for (int unsigned i = 0; i < rp.lat && bus_req; i++) @(negedge clock);
        if (bus_req) begin
          chk("bus_addr_stable", 64'({bus_req, bus_addr}), 64'({1'b1, rp.addr}));
          bus_err   = rp.err;
          bus_ack   = !rp.err || rp.both;
          bus_rdata = rp.data;
          @(negedge clock);
          bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
          chk("bus_req_drop", 64'(bus_req), 64'(0));
        end
      end
    end
  end

  // Output monitor.
  logic        prev_tag_en = 1'b0;
  logic [6:0]  prev_tag_idx = '0;
  logic [39:0] dr_e;
  logic [30:0] tag_e;
  fill_t       fill_e;
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (dr_wr_en || tag_wr_en)
          chk("wr_exclusive", 64'(dr_wr_en & tag_wr_en), 64'(0));
        if (dr_wr_en) begin
          chk("dr_pending", 64'(dr_q.size() > 0), 64'(1));
          if (dr_q.size() > 0) begin
            dr_e = dr_q.pop_front();
            chk("dr_wr", 64'({dr_wr_address, dr_wr_data}), 64'(dr_e));
          end
        end
        if (tag_wr_en) begin
          chk("tag_pending", 64'(tag_q.size() > 0), 64'(1));
          if (tag_q.size() > 0) begin
            tag_e = tag_q.pop_front();
            chk("tag_wr", 64'({tag_wr_index, tag_wr_tag, tag_wr_valid}), 64'(tag_e));
          end
        end
        if (fill_done || fill_err) begin
          chk("fill_pending", 64'(fill_q.size() > 0), 64'(1));
          if (fill_q.size() > 0) begin
            fill_e = fill_q.pop_front();
            chk("fill", 64'({fill_err, fill_done, fill_done ? fill_data : 32'h0}),
                64'({fill_e.err, !fill_e.err, fill_e.err ? 32'h0 : fill_e.data}));
          end
        end
        if (clr_done) begin
          chk("clr_pending", 64'(exp_clr > 0), 64'(1));
          if (exp_clr > 0) exp_clr--;
          chk("clr_after_127", 64'({prev_tag_en, prev_tag_idx}), 64'({1'b1, 7'd127}));
        end
      end
      prev_tag_en  = tag_wr_en;
      prev_tag_idx = tag_wr_index;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [29:0] a;
    miss_req = 1'b0; clr_req = 1'b0; miss_addr = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_outs", 64'(|{fill_done, fill_data, fill_err, busy, clr_done, bus_req, bus_addr,
                            dr_wr_en, dr_wr_address, dr_wr_data, tag_wr_en, tag_wr_index,
                            tag_wr_tag, tag_wr_valid}), 64'(0));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    do_miss(30'h0000_0123, 1'b0, 1'b0, 1'b0, 3, 3, 32'hDEADBEEF);
    do_miss(30'($urandom), 1'b1, 1'b0, 1'b0, 1, 0, $urandom);
    do_miss(30'h0ABC_DE10, 1'b0, 1'b1, 1'b0, 0, 2, $urandom);
    do_miss(30'h1234_5671, 1'b1, 1'b0, 1'b1, 2, 0, $urandom);
    do_miss(30'h2000_0000, 1'b0, 1'b1, 1'b1, 0, 0, $urandom);

    // Clear and miss together: sweep first, miss afterwards.
    wait_idle();
    for (int i = 0; i < 128; i++) tag_q.push_back({7'(i), 22'd0, 2'b00});
    exp_clr++;
    a = 30'h0155_5542;
    push_miss(a, 1'b0, 1'b0, 1'b0, 1, 1, $urandom, $urandom);
    miss_addr = a; miss_req = 1'b1; clr_req = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    n = 1;
    while (!fill_done && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("miss_after_clear", 64'(n >= 131 && n < 400), 64'(1));
    miss_req = 1'b0;
    wait_idle();

    // Pulse during TAGWR is ignored.
    push_miss(30'h0000_0200, 1'b0, 1'b0, 1'b0, 0, 1, $urandom, $urandom);
    miss_addr = 30'h0000_0200; miss_req = 1'b1;
    wait_fill();
    wait_dr();
    miss_addr = 30'h0000_0300; miss_req = 1'b1;
    @(negedge clock);
    miss_req = 1'b0;
    chk("tagwr_pulse_busy", 64'(busy), 64'(0));
    @(negedge clock);
    chk("tagwr_pulse_ignored", 64'({busy, bus_req}), 64'(0));

    // Held request during TAGWR is accepted in IDLE.
    push_miss(30'h0000_0401, 1'b0, 1'b0, 1'b0, 2, 0, $urandom, $urandom);
    miss_addr = 30'h0000_0401; miss_req = 1'b1;
    wait_fill();
    wait_dr();
    a = 30'h0000_0501;
    push_miss(a, 1'b0, 1'b0, 1'b0, 1, 1, $urandom, $urandom);
    miss_addr = a; miss_req = 1'b1;
    @(negedge clock);
    chk("held_idle_gap", 64'(busy), 64'(0));
    @(negedge clock);
    chk("held_accept", 64'({busy, bus_req}), 64'(2'b11));
    wait_fill();
    wait_idle();

    // Reset during OTHER aborts the fill with no tag write afterwards.
    push_miss(30'h0000_0610, 1'b0, 1'b0, 1'b0, 0, 20, $urandom, $urandom);
    miss_addr = 30'h0000_0610; miss_req = 1'b1;
    wait_fill();
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_busy", 64'({busy, bus_req}), 64'(2'b11));
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'(|{fill_done, fill_data, fill_err, busy, clr_done, bus_req,
                                  bus_addr, dr_wr_en, dr_wr_address, dr_wr_data, tag_wr_en,
                                  tag_wr_index, tag_wr_tag, tag_wr_valid}), 64'(0));
    plan_q.delete(); dr_q.delete(); tag_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", 64'({busy, tag_wr_en, dr_wr_en, bus_req}), 64'(0));
    end

    for (int i = 0; i < 25; i++) begin
      do_miss(30'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    repeat (3) @(negedge clock);
    chk("queues_drained", 64'({32'(plan_q.size() + fill_q.size()), 32'(dr_q.size() + tag_q.size())}),
        64'(0));
    chk("clr_drained", 64'(exp_clr), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
